// File: rtl/jelly_axi4s_video_frame_arbiter_pkg.sv
// Shared definitions for the frame-granular AXI4-Stream video arbiter.
// Holds the arbiter state encoding and the grant-index width helper.
package jelly_axi4s_video_frame_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Bits needed to index n items; never less than one so a single source still has a port.
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/jelly_axi4s_video_frame_arbiter_if.sv
// Bundle of N packed AXI4-Stream video lanes (tuser bit 0 marks frame start).
// The source side uses N sources; the sink side is instantiated with N=1.
interface jelly_axi4s_video_frame_arbiter_if #(
    parameter int N           = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TDATA_WIDTH = 32
);
    logic [N*TUSER_WIDTH-1:0] tuser;
    logic [N-1:0]             tlast;
    logic [N*TDATA_WIDTH-1:0] tdata;
    logic [N-1:0]             tvalid;
    logic [N-1:0]             tready;

    modport master (output tuser, output tlast, output tdata, output tvalid, input  tready);
    modport slave  (input  tuser, input  tlast, input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/jelly_axi4s_frame_rr_select.sv
// Rotating priority encoder: searches prev+1, prev+2, ... modulo NUM and
// reports the first requesting index, so the previous winner is checked last.
module jelly_axi4s_frame_rr_select #(
    parameter int NUM       = 3,
    parameter int SEL_WIDTH = 2
) (
    input  logic [NUM-1:0]       req,
    input  logic [SEL_WIDTH-1:0] prev,
    output logic                 found,
    output logic [SEL_WIDTH-1:0] idx
);

    int             base;
    logic [NUM-1:0] req_rot;

    always_comb begin
        base = int'(prev) + 1;
        if (base >= NUM) begin
            base = 0;
        end
        req_rot = NUM'({req, req} >> base);
        found   = 1'b0;
        idx     = '0;
        // Walk downwards so the lowest rotated position (highest priority) wins.
        for (int k = NUM - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                found = 1'b1;
                idx   = SEL_WIDTH'((base + k >= NUM) ? (base + k - NUM) : (base + k));
            end
        end
    end

endmodule

// File: rtl/jelly_axi4s_video_frame_arbiter.sv
// Frame-granular round-robin arbiter: grants one video source for one whole
// frame (frame-start beat to the last tlast of the frame) into a registered sink.
module jelly_axi4s_video_frame_arbiter
    import jelly_axi4s_video_frame_arbiter_pkg::*;
#(
    parameter int NUM          = 3,
    parameter int TUSER_WIDTH  = 1,
    parameter int TDATA_WIDTH  = 32,
    parameter int HEIGHT_WIDTH = 12,
    parameter int SEL_WIDTH    = sel_width(NUM)
) (
    input  logic                    aresetn,
    input  logic                    aclk,
    input  logic                    aclken,
    input  logic [HEIGHT_WIDTH-1:0] param_height,
    jelly_axi4s_video_frame_arbiter_if.slave  s_axi4s,
    jelly_axi4s_video_frame_arbiter_if.master m_axi4s,
    output logic [SEL_WIDTH-1:0]    m_sel,
    output logic                    busy,
    output logic                    err_short
);

    // Reset asserts asynchronously and releases on the clock.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    state_t                  state_q;
    logic [SEL_WIDTH-1:0]    sel_q;
    logic [HEIGHT_WIDTH-1:0] height_q;
    logic [HEIGHT_WIDTH-1:0] height_d;
    logic [HEIGHT_WIDTH-1:0] line_q;
    logic [HEIGHT_WIDTH-1:0] line_d;
    logic                    first_q;
    logic                    busy_q;
    logic                    err_q;

    logic                    m_valid_q;
    logic [TUSER_WIDTH-1:0]  m_user_q;
    logic                    m_last_q;
    logic [TDATA_WIDTH-1:0]  m_data_q;

    logic [TUSER_WIDTH-1:0]  src_user [NUM];
    logic [TDATA_WIDTH-1:0]  src_data [NUM];
    logic [NUM-1:0]          req;
    logic                    found;
    logic [SEL_WIDTH-1:0]    grant_idx;

    logic                    sel_valid;
    logic                    sel_last;
    logic [TUSER_WIDTH-1:0]  sel_user;
    logic [TDATA_WIDTH-1:0]  sel_data;
    logic                    out_ready;
    logic                    short_det;
    logic                    accept;
    logic [NUM-1:0]          s_ready;

    always_comb begin
        for (int i = 0; i < NUM; i++) begin
            src_user[i] = s_axi4s.tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
            src_data[i] = s_axi4s.tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
            req[i]      = s_axi4s.tvalid[i] & s_axi4s.tuser[i*TUSER_WIDTH];
        end
    end

    jelly_axi4s_frame_rr_select #(
        .NUM       (NUM),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_select (
        .req   (req),
        .prev  (sel_q),
        .found (found),
        .idx   (grant_idx)
    );

    assign sel_valid = s_axi4s.tvalid[sel_q];
    assign sel_last  = s_axi4s.tlast[sel_q];
    assign sel_user  = src_user[sel_q];
    assign sel_data  = src_data[sel_q];

    assign out_ready = ~m_valid_q | m_axi4s.tready[0];
    assign height_d  = (param_height == '0) ? HEIGHT_WIDTH'(1) : param_height;
    assign line_d    = line_q + HEIGHT_WIDTH'(1);

    // A new frame start from the granted source after its first beat cuts the frame short.
    assign short_det = (state_q == ST_GRANT) & ~first_q & sel_valid & sel_user[0];
    assign accept    = aclken & (state_q == ST_GRANT) & sel_valid & out_ready & ~short_det;

    always_comb begin
        s_ready = '0;
        if (aclken) begin
            if (state_q == ST_IDLE) begin
                // Mid-frame beats are flushed while idle; frame starts wait for a grant.
                for (int i = 0; i < NUM; i++) begin
                    s_ready[i] = s_axi4s.tvalid[i] & ~src_user[i][0];
                end
            end else begin
                s_ready[sel_q] = out_ready & ~short_det;
            end
        end
    end

    assign s_axi4s.tready = s_ready;

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= SEL_WIDTH'(NUM - 1);
            height_q <= HEIGHT_WIDTH'(1);
            line_q   <= '0;
            first_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (aclken) begin
            case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        sel_q    <= grant_idx;
                        height_q <= height_d;
                        line_q   <= '0;
                        first_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (short_det) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (accept) begin
                        first_q <= 1'b0;
                        if (sel_last) begin
                            line_q <= line_d;
                            if (line_q == height_q - HEIGHT_WIDTH'(1)) begin
                                busy_q  <= 1'b0;
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Output register drains independently of the arbiter state.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_user_q  <= '0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else if (aclken) begin
            if (accept) begin
                m_valid_q <= 1'b1;
                m_user_q  <= sel_user;
                m_last_q  <= sel_last;
                m_data_q  <= sel_data;
            end else if (m_valid_q && m_axi4s.tready[0]) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign m_axi4s.tvalid = m_valid_q;
    assign m_axi4s.tuser  = m_user_q;
    assign m_axi4s.tlast  = m_last_q;
    assign m_axi4s.tdata  = m_data_q;

    assign m_sel     = sel_q;
    assign busy      = busy_q;
    assign err_short = err_q;

endmodule

// File: tb/tb_jelly_axi4s_video_frame_arbiter.sv
// Scoreboard bench for the frame arbiter: per-source beat queues feed the DUT,
// expected output beats are queued as frames are created and popped on output.
module tb_jelly_axi4s_video_frame_arbiter;

    localparam int NUM = 3;
    localparam int TU  = 1;
    localparam int TD  = 32;
    localparam int HW  = 12;
    localparam int SW  = 2;
    localparam int PX  = 8;

    typedef struct packed {
        logic          user;
        logic          last;
        logic [TD-1:0] data;
    } beat_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          aclken = 1'b1;
    logic [HW-1:0] param_height = 12'd4;
    logic [SW-1:0] m_sel;
    logic          busy;
    logic          err_short;

    jelly_axi4s_video_frame_arbiter_if #(.N(NUM), .TUSER_WIDTH(TU), .TDATA_WIDTH(TD)) s_if ();
    jelly_axi4s_video_frame_arbiter_if #(.N(1),   .TUSER_WIDTH(TU), .TDATA_WIDTH(TD)) m_if ();

    jelly_axi4s_video_frame_arbiter #(
        .NUM          (NUM),
        .TUSER_WIDTH  (TU),
        .TDATA_WIDTH  (TD),
        .HEIGHT_WIDTH (HW),
        .SEL_WIDTH    (SW)
    ) dut (
        .aresetn      (aresetn),
        .aclk         (aclk),
        .aclken       (aclken),
        .param_height (param_height),
        .s_axi4s      (s_if),
        .m_axi4s      (m_if),
        .m_sel        (m_sel),
        .busy         (busy),
        .err_short    (err_short)
    );

    always #5 aclk = ~aclk;

    beat_t          src_q [NUM][$];
    beat_t          exp_q [$];
    logic [NUM-1:0] src_en = '0;
    bit             sink_rand = 1'b0;
    int             errors = 0;
    int             checks = 0;

    // Driver and output monitor: drive on the falling edge, evaluate the
    // handshakes that the next rising edge will perform.
    initial begin
        beat_t hb;
        beat_t ob;
        s_if.tvalid = '0;
        s_if.tuser  = '0;
        s_if.tlast  = '0;
        s_if.tdata  = '0;
        m_if.tready = 1'b1;
        forever begin
            @(negedge aclk);
            for (int i = 0; i < NUM; i++) begin
                if (src_en[i] && src_q[i].size() > 0) begin
                    hb = src_q[i][0];
                    s_if.tvalid[i]          = 1'b1;
                    s_if.tuser[i]           = hb.user;
                    s_if.tlast[i]           = hb.last;
                    s_if.tdata[i*TD +: TD]  = hb.data;
                end else begin
                    s_if.tvalid[i]          = 1'b0;
                    s_if.tuser[i]           = 1'b0;
                    s_if.tlast[i]           = 1'b0;
                    s_if.tdata[i*TD +: TD]  = '0;
                end
            end
            m_if.tready = sink_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (aresetn && aclken) begin
                for (int i = 0; i < NUM; i++) begin
                    if (s_if.tvalid[i] && s_if.tready[i]) begin
                        void'(src_q[i].pop_front());
                    end
                end
                if (m_if.tvalid[0] && m_if.tready[0]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL out_beat: unexpected beat data=%h", m_if.tdata);
                    end else begin
                        ob = exp_q.pop_front();
                        if ({m_if.tuser[0], m_if.tlast[0], m_if.tdata} !== ob) begin
                            errors++;
                            $display("FAIL out_beat: got user=%b last=%b data=%h, want user=%b last=%b data=%h",
                                     m_if.tuser[0], m_if.tlast[0], m_if.tdata, ob.user, ob.last, ob.data);
                        end
                        if (ob.user) begin
                            checks++;
                            if (m_sel !== ob.data[25:24]) begin
                                errors++;
                                $display("FAIL m_sel_at_start: got %0d want %0d", m_sel, ob.data[25:24]);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic push_frame(input int src, input int fid, input int lines);
        beat_t b;
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < PX; p++) begin
                b.user = (l == 0 && p == 0);
                b.last = (p == PX - 1);
                b.data = {8'(src), 8'(fid), 8'(l), 8'(p)};
                src_q[src].push_back(b);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic push_garbage(input int src, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.user = 1'b0;
            b.last = ((k % PX) == PX - 1);
            b.data = {16'hEEEE, 8'(src), 8'(k)};
            src_q[src].push_back(b);
        end
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NUM; i++) begin
            src_q[i].delete();
        end
        exp_q.delete();
    endtask

    task automatic apply_reset();
        src_en  = '0;
        aresetn = 1'b0;
        clear_queues();
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        repeat (4) @(negedge aclk);
    endtask

    task automatic wait_exp_le(input int n, input string what);
        int cyc;
        cyc = 0;
        while (exp_q.size() > n && cyc < 3000) begin
            @(posedge aclk);
            #2;
            cyc++;
        end
        checks++;
        if (exp_q.size() > n) begin
            errors++;
            $display("FAIL %s: timeout with %0d beats pending, wanted <= %0d", what, exp_q.size(), n);
        end
    endtask

    task automatic wait_done(input string what);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0 ||
                src_q[2].size() != 0) && cyc < 4000) begin
            @(posedge aclk);
            #2;
            cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: timeout with %0d expected beats pending, want 0", what, exp_q.size());
        end
        repeat (3) @(posedge aclk);
        #2;
        checks++;
        if ({busy, m_if.tvalid[0]} !== 2'b00) begin
            errors++;
            $display("FAIL %s_idle: got busy=%b tvalid=%b want 0 0", what, busy, m_if.tvalid[0]);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(posedge aclk);
        #2;
        checks++;
        if ({m_if.tvalid[0], m_if.tuser[0], m_if.tlast[0], m_if.tdata} !== '0) begin
            errors++;
            $display("FAIL reset_out: got valid=%b user=%b last=%b data=%h want all 0",
                     m_if.tvalid[0], m_if.tuser[0], m_if.tlast[0], m_if.tdata);
        end
        checks++;
        if (m_sel !== 2'd2) begin
            errors++;
            $display("FAIL reset_m_sel: got %0d want 2", m_sel);
        end
        checks++;
        if ({busy, err_short} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got busy=%b err_short=%b want 0 0", busy, err_short);
        end
        checks++;
        if (s_if.tready !== 3'b000) begin
            errors++;
            $display("FAIL reset_tready: got %b want 000", s_if.tready);
        end
    endtask

    task automatic test_round_robin();
        param_height = 12'd4;
        push_frame(0, 0, 4);
        push_frame(1, 0, 4);
        push_frame(2, 0, 4);
        push_frame(0, 1, 4);
        src_en = 3'b111;
        wait_done("round_robin");
        checks++;
        if (m_sel !== 2'd0) begin
            errors++;
            $display("FAIL rr_final_sel: got %0d want 0", m_sel);
        end
    endtask

    task automatic test_late_start();
        push_frame(2, 1, 4);
        src_en = 3'b100;
        wait_exp_le(16, "late_start_mid");
        push_frame(1, 1, 4);
        src_en = 3'b110;
        wait_exp_le(32, "late_start_src2_done");
        checks++;
        if (src_q[1].size() !== 32) begin
            errors++;
            $display("FAIL late_start_stalled: source 1 queue got %0d want 32", src_q[1].size());
        end
        wait_done("late_start");
    endtask

    task automatic test_mid_frame_start();
        int cyc;
        apply_reset();
        push_garbage(0, 12);
        push_frame(0, 2, 4);
        src_en = 3'b001;
        cyc = 0;
        while (src_q[0].size() > 32 && cyc < 16) begin
            @(posedge aclk);
            #2;
            cyc++;
        end
        checks++;
        if (src_q[0].size() !== 32) begin
            errors++;
            $display("FAIL flush_drain: source 0 queue got %0d want 32", src_q[0].size());
        end
        checks++;
        if ({busy, m_if.tvalid[0]} !== 2'b00) begin
            errors++;
            $display("FAIL flush_no_output: got busy=%b tvalid=%b want 0 0", busy, m_if.tvalid[0]);
        end
        wait_done("mid_frame_start");
    endtask

    task automatic test_short_frame();
        param_height = 12'd4;
        checks++;
        if (err_short !== 1'b0) begin
            errors++;
            $display("FAIL short_pre: err_short got %b want 0", err_short);
        end
        push_frame(1, 3, 2);
        push_frame(2, 3, 4);
        push_frame(1, 4, 4);
        src_en = 3'b110;
        wait_done("short_frame");
        checks++;
        if (err_short !== 1'b1) begin
            errors++;
            $display("FAIL short_flag: err_short got %b want 1", err_short);
        end
    endtask

    task automatic test_backpressure_clken();
        logic [TD+SW+4:0] snap;
        push_frame(0, 5, 4);
        push_frame(1, 5, 4);
        src_en    = 3'b011;
        sink_rand = 1'b1;
        wait_exp_le(45, "clken_mid");
        @(negedge aclk);
        aclken = 1'b0;
        #2;
        snap = {m_if.tvalid[0], m_if.tuser[0], m_if.tlast[0], m_if.tdata, m_sel, busy, err_short};
        repeat (10) begin
            @(posedge aclk);
            #2;
            checks++;
            if ({m_if.tvalid[0], m_if.tuser[0], m_if.tlast[0], m_if.tdata, m_sel, busy, err_short} !== snap) begin
                errors++;
                $display("FAIL clken_freeze: outputs changed to data=%h sel=%0d busy=%b while clock enable low",
                         m_if.tdata, m_sel, busy);
            end
            checks++;
            if (s_if.tready !== 3'b000) begin
                errors++;
                $display("FAIL clken_tready: got %b want 000", s_if.tready);
            end
        end
        @(negedge aclk);
        aclken = 1'b1;
        wait_done("backpressure");
        sink_rand = 1'b0;
    endtask

    task automatic test_async_reset();
        push_frame(2, 6, 4);
        src_en = 3'b100;
        wait_exp_le(20, "areset_mid");
        @(negedge aclk);
        #3;
        aresetn = 1'b0;
        #1;
        checks++;
        if ({m_if.tvalid[0], m_if.tuser[0], m_if.tlast[0], m_if.tdata} !== '0) begin
            errors++;
            $display("FAIL areset_out: got valid=%b data=%h want 0", m_if.tvalid[0], m_if.tdata);
        end
        checks++;
        if ({m_sel, busy, err_short} !== {2'd2, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL areset_flags: got sel=%0d busy=%b err_short=%b want 2 0 0", m_sel, busy, err_short);
        end
        src_en = '0;
        clear_queues();
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        push_frame(0, 7, 4);
        push_frame(1, 7, 4);
        src_en = 3'b011;
        wait_done("async_reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_late_start();
        test_mid_frame_start();
        test_short_frame();
        test_backpressure_clken();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
